// File: rtl/afifo_rd_ctrl.sv
// Read-side pointer and flag controller of an asynchronous FIFO.
// Keeps the read pointer in rclk and derives empty, level and underflow from the synced write pointer.
module afifo_rd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] rdata_mem,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  rundf
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AeThresh = PW'(AE_THRESH);

    logic [PW-1:0]         rbin_q, rbin_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rempty_q, rempty_d;
    logic                  rae_q, rae_d;
    logic [PW-1:0]         rlevel_q, rlevel_d;
    logic                  rundf_q, rundf_d;

    logic          rd_acc;
    logic [PW-1:0] wbin_s;

    // Gray to binary: each bit is the XOR of all gray bits at or above it.
    always_comb begin
        wbin_s = '0;
        wbin_s[PW-1] = rq2_wptr[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
        end
    end

    always_comb begin
        rd_acc   = rd_req & ~rempty_q;
        rbin_d   = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        rptr_d   = rbin_d ^ (rbin_d >> 1);
        rdata_d  = rd_acc ? rdata_mem : rdata_q;
        rvalid_d = rd_acc;
        rundf_d  = rd_req & rempty_q;
        // Flags use the post-read pointer so a final read and a fresh write resolve together.
        rempty_d = (rptr_d == rq2_wptr);
        rlevel_d = wbin_s - rbin_d;
        rae_d    = (rlevel_d <= AeThresh);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rempty_q <= 1'b1;
            rae_q    <= 1'b1;
            rlevel_q <= '0;
            rundf_q  <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rempty_q <= rempty_d;
            rae_q    <= rae_d;
            rlevel_q <= rlevel_d;
            rundf_q  <= rundf_d;
        end
    end

    assign raddr         = rbin_q[ADDR_WIDTH-1:0];
    assign rptr          = rptr_q;
    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = rae_q;
    assign rlevel        = rlevel_q;
    assign rundf         = rundf_q;

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Scoreboard bench for afifo_rd_ctrl: a word-count model predicts flags and queues expected read data.
module tb_afifo_rd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int PMOD = 32;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [AW:0]   rq2_wptr = '0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] rdata_mem;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic [DW-1:0] rdata;
    logic          rvalid, rempty, ralmost_empty, rundf;
    logic [AW:0]   rlevel;

    afifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AE_THRESH(2)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rd_req(rd_req),
        .rdata_mem(rdata_mem), .raddr(raddr), .rptr(rptr), .rdata(rdata), .rvalid(rvalid),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel), .rundf(rundf)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [DEPTH];
    assign rdata_mem = mem[raddr];

    int total = 0;
    int bad = 0;

    // Model: words written (wb) and read (m_r), both counted modulo twice the depth.
    int wb = 0;
    int m_r = 0;
    bit m_valid = 0, m_undf = 0, m_empty = 1;
    int m_level = 0;
    logic [DW-1:0] exp_q [$];

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rrst_n) begin
        m_r = 0; m_valid = 0; m_undf = 0; m_empty = 1; m_level = 0;
        exp_q.delete();
    end

    initial begin
        forever begin
            @(posedge rclk);
            if (rrst_n) begin
                m_undf  = rd_req && m_empty;
                m_valid = rd_req && !m_empty;
                if (m_valid) begin
                    exp_q.push_back(mem[m_r % DEPTH]);
                    m_r = (m_r + 1) % PMOD;
                end
                m_level = (wb - m_r + PMOD) % PMOD;
                m_empty = (m_level == 0);
            end
        end
    end

    // Monitor: compares registered outputs with the model away from the active edge.
    initial begin
        forever begin
            @(negedge rclk);
            check("rvalid", int'(rvalid), int'(m_valid));
            check("rempty", int'(rempty), int'(m_empty));
            check("rlevel", int'(rlevel), m_level);
            check("ralmost_empty", int'(ralmost_empty), int'(m_level <= 2));
            check("rundf", int'(rundf), int'(m_undf));
            check("rptr", int'(rptr), gray(m_r));
            check("raddr", int'(raddr), m_r % DEPTH);
            if (rvalid) begin
                if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
                else check("rdata", int'(rdata), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input bit req, input bit wr);
        @(negedge rclk);
        #1;
        rd_req = req;
        if (wr && ((wb - m_r + PMOD) % PMOD) < DEPTH) wb = (wb + 1) % PMOD;
        rq2_wptr = (AW+1)'(gray(wb));
    endtask

    task automatic do_reset();
        @(posedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        check("rst_rvalid", int'(rvalid), 0);
        check("rst_rempty", int'(rempty), 1);
        check("rst_rptr", int'(rptr), 0);
        check("rst_rlevel", int'(rlevel), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_ae", int'(ralmost_empty), 1);
        wb = 0;
        rq2_wptr = '0;
        rd_req = 1'b0;
        @(negedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);
        #12;
        rrst_n = 1'b1;
        step(0, 0);
        do_reset();
        // Two writes arrive with no reads.
        step(0, 1);
        step(0, 1);
        step(0, 0);
        step(0, 0);
        check("t2_level", int'(rlevel), 2);
        // Five written words, six read requests; last one underflows.
        for (int i = 0; i < 3; i++) step(0, 1);
        for (int i = 0; i < 6; i++) step(1, 0);
        step(0, 0);
        check("t3_rptr", int'(rptr), 7);
        check("t3_empty", int'(rempty), 1);
        // Fill completely, then drain 14.
        for (int i = 0; i < 16; i++) step(0, 1);
        step(0, 0);
        check("t5_full_level", int'(rlevel), 16);
        for (int i = 0; i < 14; i++) step(1, 0);
        step(0, 0);
        check("t5_ae", int'(ralmost_empty), 1);
        // Random traffic with wrap-around of the pointers.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = 8'($urandom);
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50);
        end
        // Reset while streaming at level 8.
        do_reset();
        for (int i = 0; i < 12; i++) step(0, 1);
        for (int i = 0; i < 3; i++) step(1, 0);
        step(1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0);
        check("t6_no_valid", int'(rvalid), 0);
        step(0, 0);
        step(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
